// File: rtl/prio_irq_encoder.sv
// Registered priority interrupt encoder: latches request lines into a pending
// register and grants the highest unmasked pending index over a valid/ack handshake.
module prio_irq_encoder #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int EDGE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         valid,
    output logic [N-1:0] pending
);

    // Handshake: a grant is offered while valid=1 with y held stable; it is
    // consumed on the rising clk edge where valid=1 and ack=1. ack while
    // valid=0 has no effect. valid is high exactly when the FSM is in HOLD.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] req_d;
    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic [N-1:0] cand;
    logic [W-1:0] sel;
    logic         any;

    assign set_vec = (EDGE != 0) ? (req & ~req_d) : req;
    assign cand    = pending_q & ~mask;
    assign any     = |cand;

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) sel = W'(i);
        end
    end

    always_comb begin
        clr_vec = '0;
        if (state_q == HOLD && ack) clr_vec[y_q] = 1'b1;
    end

    // Set is ORed in after the clear so a same-cycle set wins.
    assign pending_d = set_vec | (pending_q & ~clr_vec);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = HOLD;
                    y_d     = sel;
                end
            end
            HOLD: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= '0;
            pending_q <= '0;
            req_d     <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            pending_q <= pending_d;
            req_d     <= req;
        end
    end

    assign y       = y_q;
    assign valid   = (state_q == HOLD);
    assign pending = pending_q;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Bench for prio_irq_encoder: one edge-capture and one level-capture instance,
// directed scenarios plus randomized traffic against a behavioural model.
module tb_prio_irq_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_e, mask_e, req_l, mask_l;
    logic         ack_e, ack_l;
    logic [W-1:0] y_e, y_l;
    logic         valid_e, valid_l;
    logic [N-1:0] pending_e, pending_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = edge instance, 1 = level instance.
    logic [N-1:0] m_pend[2];
    logic [N-1:0] m_prev[2];
    logic         m_valid[2];
    int           m_y[2];

    prio_irq_encoder #(.N(N), .EDGE(1)) dut_edge (
        .clk(clk), .rst(rst), .req(req_e), .mask(mask_e), .ack(ack_e),
        .y(y_e), .valid(valid_e), .pending(pending_e)
    );

    prio_irq_encoder #(.N(N), .EDGE(0)) dut_level (
        .clk(clk), .rst(rst), .req(req_l), .mask(mask_l), .ack(ack_l),
        .y(y_l), .valid(valid_l), .pending(pending_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_prev[m]  = '0;
            m_valid[m] = 1'b0;
            m_y[m]     = 0;
        end
    endtask

    // One clock of the spec's rules: new requests mark lines pending, an
    // acknowledged grant retires its line, an idle encoder grants the highest
    // unmasked pending line.
    task automatic model_step(input int m, input logic [N-1:0] r, input logic [N-1:0] mk,
                              input logic a);
        logic [N-1:0] nxt;
        int best;
        nxt = m_pend[m];
        if (m_valid[m] && a) nxt[m_y[m]] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r[i] && (m == 1 || !m_prev[m][i])) nxt[i] = 1'b1;
        end
        best = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (best < 0 && m_pend[m][i] && !mk[i]) best = i;
        end
        if (m_valid[m]) begin
            if (a) m_valid[m] = 1'b0;
        end else if (best >= 0) begin
            m_valid[m] = 1'b1;
            m_y[m]     = best;
        end
        m_pend[m] = nxt;
        m_prev[m] = r;
    endtask

    task automatic cycle();
        model_step(0, req_e, mask_e, ack_e);
        model_step(1, req_l, mask_l, ack_l);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_e = '0; mask_e = '0; ack_e = 1'b0;
        req_l = '0; mask_l = '0; ack_l = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({y_e, valid_e, pending_e} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async: got y=%0d valid=%0b pending=%b want 0/0/0", y_e, valid_e, pending_e);
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (y_e !== 3'd0 || valid_e !== 1'b0 || pending_e !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_idle: got y=%0d valid=%0b pending=%b want 0/0/0", y_e, valid_e, pending_e);
            end
        end
    endtask

    task automatic test_single_edge();
        req_e = 8'b0000_0100;
        cycle();
        n_checks++;
        if (pending_e !== 8'b0000_0100 || valid_e !== 1'b0) begin
            n_fail++;
            $display("FAIL single_capture: got pending=%b valid=%0b want 00000100/0", pending_e, valid_e);
        end
        cycle();
        n_checks++;
        if (valid_e !== 1'b1 || y_e !== 3'd2) begin
            n_fail++;
            $display("FAIL single_grant: got valid=%0b y=%0d want 1/2", valid_e, y_e);
        end
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (valid_e !== 1'b1 || y_e !== 3'd2) begin
                n_fail++;
                $display("FAIL single_hold: got valid=%0b y=%0d want 1/2", valid_e, y_e);
            end
        end
        ack_e = 1'b1;
        cycle();
        ack_e = 1'b0;
        n_checks++;
        if (valid_e !== 1'b0 || pending_e !== 8'h00) begin
            n_fail++;
            $display("FAIL single_ack: got valid=%0b pending=%b want 0/00000000", valid_e, pending_e);
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (valid_e !== 1'b0) begin
                n_fail++;
                $display("FAIL single_no_regrant: got valid=%0b want 0", valid_e);
            end
        end
    endtask

    task automatic test_priority();
        req_e = 8'b0000_0001;
        cycle();
        cycle();
        n_checks++;
        if (valid_e !== 1'b1 || y_e !== 3'd0) begin
            n_fail++;
            $display("FAIL prio_low_grant: got valid=%0b y=%0d want 1/0", valid_e, y_e);
        end
        req_e = 8'b1000_0001;
        cycle();
        req_e = 8'b0000_0001;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (valid_e !== 1'b1 || y_e !== 3'd0) begin
                n_fail++;
                $display("FAIL prio_no_preempt: got valid=%0b y=%0d want 1/0", valid_e, y_e);
            end
        end
        ack_e = 1'b1;
        cycle();
        ack_e = 1'b0;
        n_checks++;
        if (valid_e !== 1'b0 || pending_e !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL prio_gap: got valid=%0b pending=%b want 0/10000000", valid_e, pending_e);
        end
        cycle();
        n_checks++;
        if (valid_e !== 1'b1 || y_e !== 3'd7) begin
            n_fail++;
            $display("FAIL prio_high_grant: got valid=%0b y=%0d want 1/7", valid_e, y_e);
        end
        ack_e = 1'b1; req_e = '0;
        cycle();
        ack_e = 1'b0;
        cycle();
    endtask

    task automatic test_mask();
        mask_e = 8'b1100_0000;
        req_e  = 8'b1100_0000;
        cycle();
        req_e = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (pending_e !== 8'b1100_0000 || valid_e !== 1'b0) begin
                n_fail++;
                $display("FAIL mask_block: got pending=%b valid=%0b want 11000000/0", pending_e, valid_e);
            end
        end
        mask_e = '0;
        cycle();
        n_checks++;
        if (valid_e !== 1'b1 || y_e !== 3'd7) begin
            n_fail++;
            $display("FAIL mask_release: got valid=%0b y=%0d want 1/7", valid_e, y_e);
        end
        ack_e = 1'b1;
        cycle();
        ack_e = 1'b0;
        cycle();
        n_checks++;
        if (valid_e !== 1'b1 || y_e !== 3'd6) begin
            n_fail++;
            $display("FAIL mask_next: got valid=%0b y=%0d want 1/6", valid_e, y_e);
        end
        ack_e = 1'b1;
        cycle();
        ack_e = 1'b0;
        cycle();
    endtask

    task automatic test_level();
        req_l = 8'b0010_0000;
        ack_l = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_checks++;
            if (valid_l !== (k % 2 == 1) || pending_l !== 8'b0010_0000 ||
                (k > 0 && y_l !== 3'd5)) begin
                n_fail++;
                $display("FAIL level_regrant: cycle %0d got valid=%0b y=%0d pending=%b want %0b/5/00100000",
                         k, valid_l, y_l, pending_l, (k % 2 == 1));
            end
        end
        req_l = '0;
        cycle();
        ack_l = 1'b0;
        n_checks++;
        if (valid_l !== 1'b0 || pending_l !== 8'h00) begin
            n_fail++;
            $display("FAIL level_drain: got valid=%0b pending=%b want 0/00000000", valid_l, pending_l);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_e  = N'($urandom_range(0, 255));
            mask_e = N'($urandom & $urandom);
            ack_e  = 1'($urandom_range(0, 1));
            req_l  = N'($urandom & $urandom & $urandom);
            mask_l = N'($urandom & $urandom);
            ack_l  = 1'($urandom_range(0, 1));
            cycle();
            n_checks++;
            if (valid_e !== m_valid[0] || y_e !== W'(m_y[0]) || pending_e !== m_pend[0]) begin
                n_fail++;
                $display("FAIL random_edge: cycle %0d got y=%0d valid=%0b pending=%b want %0d/%0b/%b",
                         k, y_e, valid_e, pending_e, m_y[0], m_valid[0], m_pend[0]);
            end
            n_checks++;
            if (valid_l !== m_valid[1] || y_l !== W'(m_y[1]) || pending_l !== m_pend[1]) begin
                n_fail++;
                $display("FAIL random_level: cycle %0d got y=%0d valid=%0b pending=%b want %0d/%0b/%b",
                         k, y_l, valid_l, pending_l, m_y[1], m_valid[1], m_pend[1]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        req_e = '0; mask_e = '0; ack_e = 1'b1;
        req_l = '0; mask_l = '0; ack_l = 1'b1;
        for (int k = 0; k < 20; k++) cycle();
        ack_e = 1'b0; ack_l = 1'b0;
        req_e = 8'b0000_1000;
        cycle();
        cycle();
        n_checks++;
        if (valid_e !== 1'b1 || y_e !== 3'd3) begin
            n_fail++;
            $display("FAIL midrst_setup: got valid=%0b y=%0d want 1/3", valid_e, y_e);
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (valid_e !== 1'b0 || y_e !== 3'd0 || pending_e !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async: got valid=%0b y=%0d pending=%b want 0/0/00000000",
                     valid_e, y_e, pending_e);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_mask();
        test_level();
        test_random();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_irq_encoder.md
Name: prio_irq_encoder

Overview:
- Parametrised, registered successor to the 8-to-3 combinational priority encoder.
- Latches N request lines into a pending register, with edge or level capture selectable per instance, plus a per-line mask.
- Presents the highest-priority unmasked pending index with a valid/ack handshake.
- Sits between raw lab event sources (buttons, timers, peripheral flags) and a controller FSM that services one event at a time.

Parameters:
- N, 8, number of request lines; legal range 2..32.
- W, $clog2(N), index width (3 for N=8); derived, do not override.
- EDGE, 1, capture mode: 1 = pending set on rising edge of req[i]; 0 = pending set while req[i] is high (level).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request lines, synchronous to clk; bit N-1 has highest priority, bit 0 lowest.
- mask  input  N  1 = line excluded from selection; pending still latches.
- ack  input  1  consumer acknowledge of the current grant.
- y  output  W  granted index; held stable while valid=1.
- valid  output  1  grant present.
- pending  output  N  pending register, for debug/status.

Behaviour:
- Reset (async, rst=1): pending=0, req_d=0, y=0, valid=0, state=IDLE. Outputs hold these values until the first clk edge after rst deasserts.
- Because req_d resets to 0, in EDGE=1 a line already high at reset release is captured as an edge on the first clock.
- Capture, every posedge:
  - EDGE=1: set_vec = req & ~req_d; req_d <= req.
  - EDGE=0: set_vec = req.
  - pending[i] <= set_vec[i] | (pending[i] & ~clr[i]).
  - clr[i] = (state==HOLD) & ack & (y==i).
  - Set has priority over clear on the same bit in the same cycle.
- Selection (combinational, internal):
  - cand = pending & ~mask.
  - sel = index of the highest set bit of cand.
  - any = |cand.
- FSM, 2 states:
  - IDLE: valid=0. If any: y<=sel, valid<=1, go to HOLD. Otherwise stay; y keeps its last value.
  - HOLD: valid=1 and y frozen. Newly arriving higher-priority requests do not preempt. Masking the held line does not withdraw the grant.
  - HOLD with ack=1: valid<=0, clear pending[y], go to IDLE.
- Handshake:
  - A grant is consumed on the posedge where valid=1 and ack=1.
  - At least one IDLE cycle (valid=0) always separates consecutive grants.
  - ack while valid=0 is ignored and has no side effects.
- Latency:
  - req rising before posedge t0 gives pending[i]=1 after t0, then valid=1 and y=i after t1. Request to grant is 2 clocks.
  - ack at posedge tA gives valid=0 after tA, and the next grant (if any) after tA+1.
- Boundary cases:
  - No unmasked pending: valid stays 0 indefinitely.
  - All lines pending: bits are granted in descending order N-1..0, one per 2 cycles under immediate ack.
  - EDGE=1, req held high: captured once. A new capture needs a low cycle on req.
  - EDGE=0, req still high at ack: the pending bit re-sets the same cycle (set wins), so the same index is re-granted after the IDLE gap.
  - rst asserted mid-HOLD: immediate return to reset values; the in-flight grant is lost.

Test Plan:
- Reset/idle, N=8, EDGE=1:
  - rst=1 at t=0, release at 2 clk, req=0 → y=000, valid=0, pending=00000000 throughout.
- Single edge:
  - req=00000100 held → pending=00000100 after 1 clk; valid=1, y=010 after 2 clk.
  - Hold ack=0 for 5 clk → y and valid stable.
  - ack=1 for 1 clk → valid=0, pending=0. No re-grant while req stays high.
- Priority and no-preemption:
  - req=00000001 gives grant y=000.
  - During HOLD, pulse req=10000000 → y stays 000 until ack.
  - After the IDLE gap → y=111, valid=1.
- Mask:
  - mask=11000000, pulse req=11000000 → pending=11000000, valid=0.
  - Clear mask to 00000000 → y=111, then after ack, y=110.
- Level mode, EDGE=0:
  - req=00100000 held; ack each grant → y=101 re-granted every 2 clk.
  - Drop req, ack last grant → valid=0, pending=0.
- Reset mid-grant:
  - Assert rst asynchronously (between edges) while valid=1, y=011 → valid=0, y=000, pending=0 immediately, without waiting for a clk edge.
